// File: rtl/cr_iu_regbank_pkg.sv
// Shared definitions for the gated-clock register bank.
//   clr_state_e : clear-sequencer state encoding
//   clog2()     : ceil(log2(n)), minimum 1, for sizing index fields
package cr_iu_regbank_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cr_iu_regbank_entry.sv
// One register-bank entry: own clock gate plus a byte-enabled data register.
//   forever_cpuclk, cpurst_b           : clock / async active-low reset
//   cp0_yy_clk_en, pad_yy_*, x_randclk : clock-gate controls passed to the cell
//   local_en                           : update this entry on the next edge
//   clr                                : load RST_VAL instead of write data
//   wr_data, wr_be                     : write data and byte strobes
//   data_q                             : stored value
module cr_iu_regbank_entry #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               cp0_yy_clk_en,
  input  logic               pad_yy_gate_clk_en_b,
  input  logic               pad_yy_test_mode,
  input  logic               x_randclk_reg_mod_en_w32,
  input  logic               local_en,
  input  logic               clr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  output logic [WIDTH-1:0]   data_q
);

  localparam int NB = WIDTH / 8;

  logic             entry_clk;
  logic [WIDTH-1:0] data_nxt;

  gated_clk_cell x_gated_clk (
    .clk_in               (forever_cpuclk),
    .global_en            (cp0_yy_clk_en),
    .module_en            (x_randclk_reg_mod_en_w32),
    .local_en             (local_en),
    .external_en          (1'b0),
    .pad_yy_gate_clk_en_b (pad_yy_gate_clk_en_b),
    .pad_yy_test_mode     (pad_yy_test_mode),
    .clk_out              (entry_clk)
  );

  always_comb begin
    data_nxt = data_q;
    if (clr) data_nxt = RST_VAL;
    else begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) data_nxt[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  // The gate may be forced open (bypass, test mode, module enable), so the
  // register still qualifies its update with local_en.
  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b)     data_q <= RST_VAL;
    else if (local_en) data_q <= data_nxt;
  end

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate.
//   clk_in                : free-running clock
//   global_en, module_en  : coarse enables (module_en opens the gate for the whole module)
//   local_en              : per-cell enable
//   external_en           : unconditional enable
//   pad_yy_gate_clk_en_b  : low forces the gate open
//   pad_yy_test_mode      : high forces the gate open for scan
//   clk_out               : gated clock
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_gate_clk_en_b,
  input  logic pad_yy_test_mode,
  output logic clk_out
);

  logic clk_en;
  logic en_lat;

  assign clk_en = (global_en & (module_en | local_en)) | external_en
                | ~pad_yy_gate_clk_en_b | pad_yy_test_mode;

  // Enable is captured while the clock is low so clk_out cannot glitch.
  always_latch begin
    if (!clk_in) en_lat <= clk_en;
  end

  assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/cr_iu_gated_clk_regbank.sv
// Register bank with one gated clock per entry, byte-enabled writes,
// combinational reads and a sequential clear engine.
//   forever_cpuclk / cpurst_b      : clock, async active-low reset
//   cp0_yy_clk_en, pad_yy_*, x_randclk_reg_mod_en_w32 : clock-gate controls
//   wr_en/wr_idx/wr_data/wr_be     : write request, wr_ready = accepted
//   rd_idx -> rd_data/rd_valid     : combinational read port
//   clr_req -> clr_busy/clr_done   : clear all entries, one per cycle
//   x_reg_valid                    : per-entry valid bits
module cr_iu_gated_clk_regbank
  import cr_iu_regbank_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               AW      = 2
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               cp0_yy_clk_en,
  input  logic               pad_yy_gate_clk_en_b,
  input  logic               pad_yy_test_mode,
  input  logic               x_randclk_reg_mod_en_w32,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  output logic               wr_ready,
  input  logic [AW-1:0]      rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [DEPTH-1:0]   x_reg_valid
);

  clr_state_e                   state_q, state_nxt;
  logic [AW-1:0]                ptr_q;
  logic                         wr_acc;
  logic                         clearing;
  logic [DEPTH-1:0]             wr_hit, clr_hit, local_en;
  logic [DEPTH-1:0][WIDTH-1:0]  entry_q;

  // ---------------- clear FSM ----------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= CLR_IDLE;
    else           state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      CLR_IDLE:  if (clr_req) state_nxt = CLR_CLEAR;
      CLR_CLEAR: if (ptr_q == AW'(DEPTH-1)) state_nxt = CLR_DONE;
      CLR_DONE:  state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q != CLR_IDLE);
    clr_done = (state_q == CLR_DONE);
    wr_ready = (state_q == CLR_IDLE);
    clearing = (state_q == CLR_CLEAR);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)                          ptr_q <= '0;
    else if (state_q == CLR_IDLE && clr_req) ptr_q <= '0;
    else if (clearing)                      ptr_q <= ptr_q + AW'(1);
  end

  // ---------------- write / clear select ----------------
  assign wr_acc = wr_en & wr_ready & (32'(wr_idx) < 32'(DEPTH));

  for (genvar i = 0; i < DEPTH; i++) begin : g_sel
    assign wr_hit[i]   = wr_acc   & (wr_idx == AW'(i));
    assign clr_hit[i]  = clearing & (ptr_q  == AW'(i));
    assign local_en[i] = wr_hit[i] | clr_hit[i];
  end

  // Writes and clears never coincide: wr_ready is low while clearing.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) x_reg_valid <= '0;
    else           x_reg_valid <= (x_reg_valid | wr_hit) & ~clr_hit;
  end

  // ---------------- entries ----------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    cr_iu_regbank_entry #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) x_entry (
      .forever_cpuclk           (forever_cpuclk),
      .cpurst_b                 (cpurst_b),
      .cp0_yy_clk_en            (cp0_yy_clk_en),
      .pad_yy_gate_clk_en_b     (pad_yy_gate_clk_en_b),
      .pad_yy_test_mode         (pad_yy_test_mode),
      .x_randclk_reg_mod_en_w32 (x_randclk_reg_mod_en_w32),
      .local_en                 (local_en[i]),
      .clr                      (clearing),
      .wr_data                  (wr_data),
      .wr_be                    (wr_be),
      .data_q                   (entry_q[i])
    );
  end

  // ---------------- read port ----------------
  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == AW'(i)) begin
        rd_data  = entry_q[i];
        rd_valid = x_reg_valid[i];
      end
    end
  end

endmodule

// File: tb/tb_cr_iu_gated_clk_regbank.sv
module tb_cr_iu_gated_clk_regbank;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        cp0_yy_clk_en, pad_yy_gate_clk_en_b, pad_yy_test_mode, x_randclk_reg_mod_en_w32;
  logic        wr_en, clr_req;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ready, rd_valid, clr_busy, clr_done;
  logic [31:0] rd_data;
  logic [3:0]  x_reg_valid;
  logic        wr_ready3, rd_valid3, clr_busy3, clr_done3;
  logic [31:0] rd_data3;
  logic [2:0]  x_reg_valid3;

  int checks = 0;
  int errors = 0;

  always #5 forever_cpuclk = ~forever_cpuclk;

  cr_iu_gated_clk_regbank #(.WIDTH(32), .DEPTH(4), .RST_VAL(32'h0), .AW(2)) dut (
    .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
    .cp0_yy_clk_en(cp0_yy_clk_en), .pad_yy_gate_clk_en_b(pad_yy_gate_clk_en_b),
    .pad_yy_test_mode(pad_yy_test_mode), .x_randclk_reg_mod_en_w32(x_randclk_reg_mod_en_w32),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .x_reg_valid(x_reg_valid)
  );

  cr_iu_gated_clk_regbank #(.WIDTH(32), .DEPTH(3), .RST_VAL(32'h0), .AW(2)) dut3 (
    .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
    .cp0_yy_clk_en(cp0_yy_clk_en), .pad_yy_gate_clk_en_b(pad_yy_gate_clk_en_b),
    .pad_yy_test_mode(pad_yy_test_mode), .x_randclk_reg_mod_en_w32(x_randclk_reg_mod_en_w32),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_be(wr_be), .wr_ready(wr_ready3),
    .rd_idx(rd_idx), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .clr_req(clr_req), .clr_busy(clr_busy3), .clr_done(clr_done3), .x_reg_valid(x_reg_valid3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [1:0]  rd_idx;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic [3:0]  exp_vec;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  localparam logic [31:0] D1 = 32'h55667788;
  localparam logic [31:0] D2 = 32'h99AABBCC;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt, done_at;

    //            wr   idx  data          be       rd   exp_data      v     vec
    vec[0]  = '{1'b0, 2'd0, 32'h0,        4'b0000, 2'd0, 32'h00000000, 1'b0, 4'b0000};
    vec[1]  = '{1'b0, 2'd0, 32'h0,        4'b0000, 2'd1, 32'h00000000, 1'b0, 4'b0000};
    vec[2]  = '{1'b0, 2'd0, 32'h0,        4'b0000, 2'd2, 32'h00000000, 1'b0, 4'b0000};
    vec[3]  = '{1'b0, 2'd0, 32'h0,        4'b0000, 2'd3, 32'h00000000, 1'b0, 4'b0000};
    vec[4]  = '{1'b1, 2'd2, 32'hAABBCCDD, 4'b1111, 2'd2, 32'hAABBCCDD, 1'b1, 4'b0100};
    vec[5]  = '{1'b1, 2'd2, 32'h11223344, 4'b0101, 2'd2, 32'hAA22CC44, 1'b1, 4'b0100};
    vec[6]  = '{1'b1, 2'd0, 32'h12345678, 4'b0000, 2'd0, 32'h00000000, 1'b1, 4'b0101};
    vec[7]  = '{1'b1, 2'd1, 32'hDEADBEEF, 4'b1000, 2'd1, 32'hDE000000, 1'b1, 4'b0111};
    vec[8]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 4'b1111, 2'd3, 32'hFFFFFFFF, 1'b1, 4'b1111};
    vec[9]  = '{1'b0, 2'd0, 32'h0,        4'b0000, 2'd2, 32'hAA22CC44, 1'b1, 4'b1111};
    vec[10] = '{1'b0, 2'd0, 32'h0,        4'b0000, 2'd1, 32'hDE000000, 1'b1, 4'b1111};

    cpurst_b = 1'b0;
    cp0_yy_clk_en = 1'b1; pad_yy_gate_clk_en_b = 1'b1; pad_yy_test_mode = 1'b0;
    x_randclk_reg_mod_en_w32 = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_be = '0; rd_idx = '0; clr_req = 1'b0;

    // Reset state
    repeat (2) @(posedge forever_cpuclk);
    #1;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_clr_busy", clr_busy, 1'b0);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_valid",    x_reg_valid, 4'b0000);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;

    // Table-driven write/read vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge forever_cpuclk);
      wr_en = vec[i].wr_en; wr_idx = vec[i].wr_idx; wr_data = vec[i].wr_data;
      wr_be = vec[i].wr_be; rd_idx = vec[i].rd_idx;
      @(posedge forever_cpuclk); #1;
      chk($sformatf("v%0d_rd_data", i),  rd_data,     vec[i].exp_data);
      chk($sformatf("v%0d_rd_valid", i), rd_valid,    vec[i].exp_valid);
      chk($sformatf("v%0d_valid_vec", i), x_reg_valid, vec[i].exp_vec);
    end
    @(negedge forever_cpuclk);
    wr_en = 1'b0;

    // Gate forced open with no write: data must hold
    pad_yy_gate_clk_en_b = 1'b0; x_randclk_reg_mod_en_w32 = 1'b1; rd_idx = 2'd2;
    repeat (3) @(posedge forever_cpuclk);
    #1;
    chk("bypass_hold", rd_data, 32'hAA22CC44);
    @(negedge forever_cpuclk);
    pad_yy_gate_clk_en_b = 1'b1; x_randclk_reg_mod_en_w32 = 1'b0;

    // DEPTH=3 instance: write to idx 3 was dropped
    rd_idx = 2'd3; #1;
    chk("d3_rd3_data",  rd_data3, 32'h0);
    chk("d3_rd3_valid", rd_valid3, 1'b0);
    chk("d3_valid_vec", x_reg_valid3, 3'b111);
    rd_idx = 2'd2; #1;
    chk("d3_rd2_data",  rd_data3, 32'hAA22CC44);

    // Clear with simultaneous write, held write during busy, clr_req ignored when busy
    @(negedge forever_cpuclk);
    clr_req = 1'b1; wr_en = 1'b1; wr_idx = 2'd1; wr_data = D1; wr_be = 4'b1111; rd_idx = 2'd1;
    #1;
    chk("no_bypass", rd_data, 32'hDE000000);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge forever_cpuclk); #1;
      if (c == 0) chk("clr_wr_first", rd_data, D1);
      chk($sformatf("c%0d_ready", c), wr_ready, !clr_busy);
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_at = busy_cnt; end
      if (!clr_busy) break;
      wr_data = D2;
      clr_req = (busy_cnt == 3) || clr_done;
    end
    clr_req = 1'b0;
    chk("clr_busy_cycles", busy_cnt, 5);
    chk("clr_done_count",  done_cnt, 1);
    chk("clr_done_at",     done_at,  5);
    chk("clr_valid_vec",   x_reg_valid, 4'b0000);
    chk("clr_rd1_data",    rd_data, 32'h0);
    @(posedge forever_cpuclk); #1;
    chk("req_ignored",     clr_busy, 1'b0);
    chk("held_wr_data",    rd_data, D2);
    chk("held_wr_vec",     x_reg_valid, 4'b0010);
    @(negedge forever_cpuclk);
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      rd_idx = 2'(i); #1;
      chk($sformatf("clr_rd%0d", i), rd_data, 32'h0);
    end

    // Reset in the second CLEAR cycle
    @(negedge forever_cpuclk);
    clr_req = 1'b1; rd_idx = 2'd1;
    @(posedge forever_cpuclk);
    @(negedge forever_cpuclk);
    clr_req = 1'b0;
    @(posedge forever_cpuclk); #1;
    chk("mid_busy",  clr_busy, 1'b1);
    chk("mid_rd1",   rd_data, D2);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b0; #1;
    chk("abort_busy",  clr_busy, 1'b0);
    chk("abort_done",  clr_done, 1'b0);
    chk("abort_ready", wr_ready, 1'b1);
    chk("abort_valid", x_reg_valid, 4'b0000);
    chk("abort_rd1",   rd_data, 32'h0);
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge forever_cpuclk); #1;
      if (clr_done) done_cnt++;
      if (clr_busy) busy_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_busy", busy_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_iu_gated_clk_regbank.md
CR_IU_GATED_CLK_REGBANK -- requirements
Module: cr_iu_gated_clk_regbank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: entry width in bits, a multiple of 8, range 8..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, range 1..16.
REQ-003 SHALL have parameter RST_VAL, default 0: value loaded into every entry on reset and on clear.
REQ-004 SHALL have parameter AW, default 2: index width, at least ceil(log2(DEPTH)), minimum 1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 forever_cpuclk  in  1  free-running CPU clock; the only clock.
REQ-007 cpurst_b  in  1  asynchronous active-low reset.
REQ-008 cp0_yy_clk_en  in  1  global clock-gate enable.
REQ-009 pad_yy_gate_clk_en_b  in  1  clock-gate bypass, active-low.
REQ-010 pad_yy_test_mode  in  1  scan test mode.
REQ-011 x_randclk_reg_mod_en_w32  in  1  module clock-gate enable.
REQ-012 wr_en  in  1  write request.
REQ-013 wr_idx  in  AW  write entry index.
REQ-014 wr_data  in  WIDTH  write data.
REQ-015 wr_be  in  WIDTH/8  byte write strobes.
REQ-016 wr_ready  out  1  write accepted this cycle when high.
REQ-017 rd_idx  in  AW  read entry index.
REQ-018 rd_data  out  WIDTH  read data.
REQ-019 rd_valid  out  1  valid bit of the entry at rd_idx.
REQ-020 clr_req  in  1  request to clear all entries.
REQ-021 clr_busy  out  1  clear sequence in progress.
REQ-022 clr_done  out  1  one-cycle pulse when the clear sequence completes.
REQ-023 x_reg_valid  out  DEPTH  per-entry valid bits.

Function
REQ-024 A write SHALL be accepted when wr_en=1, wr_ready=1 and wr_idx<DEPTH; wr_ready SHALL equal !clr_busy.
REQ-025 An accepted write SHALL update only the bytes whose wr_be bit is 1, SHALL set x_reg_valid[wr_idx], and SHALL be visible on rd_data the next cycle, with no same-cycle bypass.
REQ-026 An accepted write with wr_be all-zero SHALL still set the valid bit and leave the data unchanged.
REQ-027 A write with wr_idx>=DEPTH SHALL be dropped silently, with no state change.
REQ-028 A write presented while clr_busy=1 SHALL be dropped; the requester must hold it until wr_ready=1.
REQ-029 rd_data and rd_valid SHALL be combinational from rd_idx; rd_idx>=DEPTH SHALL return rd_data=0 and rd_valid=0.
REQ-030 The clear FSM SHALL have three states: IDLE, CLEAR and DONE.
REQ-031 IDLE SHALL go to CLEAR on clr_req=1 and reset the pointer to 0.
REQ-032 CLEAR SHALL write RST_VAL to entry[ptr] and clear valid[ptr] each cycle, then increment ptr.
REQ-033 CLEAR SHALL go to DONE in the cycle ptr==DEPTH-1.
REQ-034 DONE SHALL assert clr_done for one cycle and return to IDLE.
REQ-035 clr_busy SHALL be 1 in CLEAR and DONE, giving exactly DEPTH+1 busy cycles per clear.
REQ-036 clr_req in CLEAR or DONE SHALL be ignored and not queued.
REQ-037 clr_req in the same cycle as a write, while in IDLE, SHALL accept the write first; the clear then overwrites it.
REQ-038 Each entry SHALL have its own gated_clk_cell instance with local_en = (accepted write to that entry) | (CLEAR && ptr==entry) and external_en=0; the other pins SHALL connect to the same-named ports.
REQ-039 Valid bits, the FSM and the pointer SHALL be clocked by forever_cpuclk, not by the gated clocks.

Reset
REQ-040 While cpurst_b=0, all entries SHALL be RST_VAL, x_reg_valid=0, FSM=IDLE and ptr=0.
REQ-041 While cpurst_b=0, wr_ready=1, clr_busy=0 and clr_done=0.
REQ-042 Reset asserted mid-clear SHALL abort the sequence immediately, and no clr_done SHALL be produced.

Structure
REQ-043 FSM state encodings and a clog2 helper function SHALL live in the shared package cr_iu_regbank_pkg.
REQ-044 One entry (gated clock cell plus byte-enabled data register) SHALL be a sub-module, cr_iu_regbank_entry, instantiated DEPTH times.

Verification
REQ-045 Reset, then read idx 0..3 -> rd_data=0x00000000, rd_valid=0 for all.
REQ-046 Write idx 2, data 0xAABBCCDD, be=4'b1111, then idx 2, data 0x11223344, be=4'b0101 -> read idx 2 next cycle = 0xAA22CC44, valid[2]=1.
REQ-047 Write all 4 entries, pulse clr_req -> clr_busy high for 5 cycles, clr_done high in the 5th, all entries=RST_VAL, x_reg_valid=4'b0000.
REQ-048 Write to idx 1 held during CLEAR -> wr_ready=0 and the write is dropped; it lands only after wr_ready returns to 1.
REQ-049 DEPTH=3: write idx 3, data 0xFFFFFFFF -> no state change; read idx 3 -> 0 and rd_valid=0.
REQ-050 Assert cpurst_b=0 in the 2nd CLEAR cycle -> FSM=IDLE, no clr_done pulse, all outputs at reset values.
